fp_add_sequencer: RTL and testbench

//   Multi-cycle controller for the floating-point add datapath. Accepts two packed

---
 rtl/fp_add_sequencer_if.sv | 29 ++
 rtl/fp_add_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_sequencer_if.sv
// Operand/result handshake bundle for the floating-point add sequencer.
// The master side supplies operands and consumes results; the slave side
// is the sequencer itself.
interface fp_add_sequencer_if #(
  parameter int EXP_N  = 8,
  parameter int FRAC_N = 23
);
  localparam int W = 1 + EXP_N + FRAC_N;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp_add_sequencer.sv
// Multi-cycle floating-point adder controller. Operands are captured in IDLE,
// then one clock each is spent aligning, adding, normalising and packing the
// sum before it is offered on the result handshake. Truncating rounding only;
// denormals are flushed to zero and there is no NaN handling.
module fp_add_sequencer #(
  parameter int EXP_N  = 8,
  parameter int FRAC_N = 23
) (
  input logic               clock,
  input logic               reset,
  fp_add_sequencer_if.slave bus
);
  localparam int W  = 1 + EXP_N + FRAC_N;
  localparam int MW = FRAC_N + 2;
  localparam int EW = EXP_N + 2;
  localparam logic [EXP_N-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] EXP_MAX  = signed'({2'b00, EXP_ONES});

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic                  sign_q, sign_d, sub_q, sub_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d, addend_q, addend_d;
  logic                  zero_q, zero_d;
  logic                  spec_q, spec_d, spec_ovf_q, spec_ovf_d;
  logic [W-1:0]          spec_res_q, spec_res_d;
  logic [W-1:0]          result_q, result_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  out_valid_q, out_valid_d;

  logic                  sign_a, sign_b, zero_a, zero_b, inf_a, inf_b, a_is_l;
  logic [EXP_N-1:0]      exp_a, exp_b, exp_l, exp_s, exp_diff;
  logic [W-2:0]          mag_a, mag_b;
  logic [MW-1:0]         mant_a, mant_b, mant_l, mant_s, aligned;
  logic                  spec_hit, spec_ovf;
  logic [W-1:0]          spec_res;
  logic [MW-1:0]         norm_m;
  logic signed [EW-1:0]  norm_e;
  logic                  norm_zero;
  int                    hi;

  // Field decode and magnitude ordering of the captured operands.
  assign sign_a   = a_q[W-1];
  assign sign_b   = b_q[W-1];
  assign exp_a    = a_q[W-2:FRAC_N];
  assign exp_b    = b_q[W-2:FRAC_N];
  assign zero_a   = (exp_a == '0);
  assign zero_b   = (exp_b == '0);
  assign inf_a    = (exp_a == EXP_ONES);
  assign inf_b    = (exp_b == EXP_ONES);
  assign mag_a    = zero_a ? '0 : a_q[W-2:0];
  assign mag_b    = zero_b ? '0 : b_q[W-2:0];
  assign mant_a   = zero_a ? '0 : {2'b01, a_q[FRAC_N-1:0]};
  assign mant_b   = zero_b ? '0 : {2'b01, b_q[FRAC_N-1:0]};
  assign a_is_l   = (mag_a >= mag_b);
  assign exp_l    = a_is_l ? exp_a : exp_b;
  assign exp_s    = a_is_l ? exp_b : exp_a;
  assign mant_l   = a_is_l ? mant_a : mant_b;
  assign mant_s   = a_is_l ? mant_b : mant_a;
  assign exp_diff = exp_l - exp_s;
  assign aligned  = (32'(exp_diff) >= MW) ? '0 : (mant_s >> exp_diff);

  // Infinity and double-zero operands bypass the arithmetic entirely.
  always_comb begin
    spec_hit = inf_a | inf_b | (zero_a & zero_b);
    spec_res = '0;
    spec_ovf = 1'b0;
    if (inf_a && inf_b && (sign_a != sign_b)) begin
      spec_res = {1'b0, EXP_ONES, {FRAC_N{1'b0}}};
      spec_ovf = 1'b1;
    end else if (inf_a) begin
      spec_res = {sign_a, EXP_ONES, {FRAC_N{1'b0}}};
    end else if (inf_b) begin
      spec_res = {sign_b, EXP_ONES, {FRAC_N{1'b0}}};
    end
  end

  // Normaliser: one right shift on carry-out, otherwise left to the leading one.
  always_comb begin
    norm_m    = mant_q;
    norm_e    = exp_q;
    norm_zero = 1'b0;
    hi        = 0;
    if (mant_q[MW-1]) begin
      norm_m = mant_q >> 1;
      norm_e = exp_q + EW'(1);
    end else if (mant_q == '0) begin
      norm_zero = 1'b1;
    end else begin
      for (int i = 0; i < MW - 1; i++) begin
        if (mant_q[i]) hi = i;
      end
      norm_m = mant_q << ((MW - 2) - hi);
      norm_e = exp_q - EW'((MW - 2) - hi);
    end
  end

  // Next-state and datapath register updates, one stage per state.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    addend_d    = addend_q;
    zero_d      = zero_q;
    spec_d      = spec_q;
    spec_ovf_d  = spec_ovf_q;
    spec_res_d  = spec_res_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sign_d     = a_is_l ? sign_a : sign_b;
        sub_d      = sign_a ^ sign_b;
        exp_d      = signed'({2'b00, exp_l});
        mant_d     = mant_l;
        addend_d   = aligned;
        spec_d     = spec_hit;
        spec_res_d = spec_res;
        spec_ovf_d = spec_ovf;
        state_d    = S_ADD;
      end
      S_ADD: begin
        mant_d  = sub_q ? (mant_q - addend_q) : (mant_q + addend_q);
        state_d = S_NORM;
      end
      S_NORM: begin
        mant_d  = norm_m;
        exp_d   = norm_e;
        zero_d  = norm_zero;
        state_d = S_PACK;
      end
      S_PACK: begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (spec_q) begin
          result_d   = spec_res_q;
          overflow_d = spec_ovf_q;
        end else if (zero_q) begin
          result_d = '0;
        end else if (!exp_q[EW-1] && (exp_q >= EXP_MAX)) begin
          result_d   = {sign_q, EXP_ONES, {FRAC_N{1'b0}}};
          overflow_d = 1'b1;
        end else if (exp_q[EW-1] || (exp_q == '0)) begin
          result_d    = {sign_q, {(EXP_N + FRAC_N){1'b0}}};
          underflow_d = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[EXP_N-1:0], mant_q[FRAC_N-1:0]};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      addend_q    <= '0;
      zero_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_ovf_q  <= 1'b0;
      spec_res_q  <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      addend_q    <= addend_d;
      zero_q      <= zero_d;
      spec_q      <= spec_d;
      spec_ovf_q  <= spec_ovf_d;
      spec_res_q  <= spec_res_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer (single precision configuration).
// Expected results come from a real-number style reference model working on
// integer mantissas and exponents.
module tb_fp_add_sequencer;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fp_add_sequencer_if #(.EXP_N(8), .FRAC_N(23)) bus ();

  fp_add_sequencer #(.EXP_N(8), .FRAC_N(23)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: returns {overflow, underflow, result}.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic        sx, sy, sl;
    int          ex, ey, el, es, e, d;
    longint      mx, my, ml, ms, m, kx, ky;
    logic [7:0]  e8;
    logic [22:0] f23;
    sx = x[31];
    sy = y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ex == 255 && ey == 255) begin
      if (sx != sy) return {2'b10, 32'h7F800000};
      return {2'b00, sx, 8'hFF, 23'h0};
    end
    if (ex == 255) return {2'b00, sx, 8'hFF, 23'h0};
    if (ey == 255) return {2'b00, sy, 8'hFF, 23'h0};
    if (ex == 0 && ey == 0) return 34'h0;
    mx = (ex == 0) ? 64'sd0 : ((longint'(1) << 23) + longint'(x[22:0]));
    my = (ey == 0) ? 64'sd0 : ((longint'(1) << 23) + longint'(y[22:0]));
    kx = (ex == 0) ? 64'sd0 : longint'(x[30:0]);
    ky = (ey == 0) ? 64'sd0 : longint'(y[30:0]);
    if (kx >= ky) begin
      sl = sx; el = ex; es = ey; ml = mx; ms = my;
    end else begin
      sl = sy; el = ey; es = ex; ml = my; ms = mx;
    end
    d  = el - es;
    ms = (d >= 25) ? 64'sd0 : (ms >>> d);
    m  = (sx == sy) ? (ml + ms) : (ml - ms);
    e  = el;
    if (m == 0) return 34'h0;
    if (m >= (longint'(1) << 24)) begin
      m = m >>> 1;
      e = e + 1;
    end
    while (m < (longint'(1) << 23)) begin
      m = m <<< 1;
      e = e - 1;
    end
    if (e >= 255) return {2'b10, sl, 8'hFF, 23'h0};
    if (e <= 0) return {2'b01, sl, 31'h0};
    e8  = e[7:0];
    f23 = m[22:0];
    return {2'b00, sl, e8, f23};
  endfunction

  // Random operand with occasional zero/denormal and infinity encodings.
  function automatic logic [31:0] rand_operand();
    logic [7:0]  ex;
    int          cat;
    cat = $urandom_range(0, 9);
    if (cat == 0)      ex = 8'h00;
    else if (cat == 1) ex = 8'hFF;
    else               ex = 8'($urandom_range(1, 254));
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  // Present one operand pair and wait for the accepting edge.
  task automatic start_op(input logic [31:0] xa, input logic [31:0] xb);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    bus.a        = xa;
    bus.b        = xb;
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges from acceptance until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  // Hold off for some cycles, then take the result.
  task automatic finish_op(input int delay, output logic [31:0] r, output logic o, output logic u);
    repeat (delay) begin
      @(posedge clock); #1;
    end
    r = bus.result;
    o = bus.overflow;
    u = bus.underflow;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.result !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_result got %h exp 00000000", bus.result);
    end
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_flags got %b%b exp 00", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [11] = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h3F800000,
                             32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 32'hFF800000,
                             32'h00000000, 32'h00000000, 32'h00123456};
    logic [31:0] tb [11] = '{32'h3F800000, 32'hBFC00000, 32'hBF800000, 32'h30800000,
                             32'h7F7FFFFF, 32'h80C00000, 32'hFF800000, 32'h3F800000,
                             32'h80000000, 32'hC0A00000, 32'h3F800000};
    logic [33:0] te [11] = '{{2'b00, 32'h40000000}, {2'b00, 32'h00000000}, {2'b00, 32'h40000000},
                             {2'b00, 32'h3F800000}, {2'b10, 32'h7F800000}, {2'b01, 32'h80000000},
                             {2'b10, 32'h7F800000}, {2'b00, 32'hFF800000}, {2'b00, 32'h00000000},
                             {2'b00, 32'hC0A00000}, {2'b00, 32'h3F800000}};
    logic [31:0] r;
    logic        o, u;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      start_op(ta[i], tb[i]);
      wait_valid(lat);
      checks++;
      if (lat != 5) begin
        errors++; $display("[TB] FAIL dir_latency[%0d] got %0d exp 5", i, lat);
      end
      finish_op(i % 3, r, o, u);
      checks++;
      if ({o, u, r} !== te[i]) begin
        errors++;
        $display("[TB] FAIL dir_result[%0d] %h+%h got %b%b_%h exp %b_%h",
                 i, ta[i], tb[i], o, u, r, te[i][33:32], te[i][31:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] xa, xb, r;
    logic [33:0] exp_v;
    logic        o, u;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      xa = rand_operand();
      xb = rand_operand();
      if ($urandom_range(0, 1) == 1 && xa[30:23] != 8'h00 && xa[30:23] < 8'hF0) begin
        xb[30:23] = xa[30:23] + 8'($urandom_range(0, 2));
      end
      exp_v = ref_add(xa, xb);
      start_op(xa, xb);
      wait_valid(lat);
      checks++;
      if (lat != 5) begin
        errors++; $display("[TB] FAIL rnd_latency[%0d] got %0d exp 5", i, lat);
      end
      finish_op($urandom_range(0, 3), r, o, u);
      checks++;
      if ({o, u, r} !== exp_v) begin
        errors++;
        $display("[TB] FAIL rnd_result[%0d] %h+%h got %b%b_%h exp %b_%h",
                 i, xa, xb, o, u, r, exp_v[33:32], exp_v[31:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] exp_v;
    logic [31:0] r;
    logic        o, u;
    int          lat;
    exp_v = ref_add(32'h3FC00000, 32'h40100000);
    start_op(32'h3FC00000, 32'h40100000);
    wait_valid(lat);
    checks++;
    if (lat != 5) begin
      errors++; $display("[TB] FAIL bp_latency got %0d exp 5", lat);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d] got valid=%b ready=%b exp valid=1 ready=0",
                 c, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.result !== exp_v[31:0]) begin
        errors++; $display("[TB] FAIL bp_result[%0d] got %h exp %h", c, bus.result, exp_v[31:0]);
      end
      @(posedge clock); #1;
    end
    finish_op(0, r, o, u);
    checks++;
    if ({o, u, r} !== exp_v) begin
      errors++; $display("[TB] FAIL bp_final got %b%b_%h exp %b_%h", o, u, r, exp_v[33:32], exp_v[31:0]);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r;
    logic        o, u;
    int          lat;
    bit          seen;
    start_op(32'h3F800000, 32'h3F800000);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state got ready=%b valid=%b exp ready=1 valid=0",
               bus.in_ready, bus.out_valid);
    end
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_discard got out_valid=1 exp 0");
    end
    start_op(32'h40400000, 32'hBF800000);
    wait_valid(lat);
    finish_op(0, r, o, u);
    checks++;
    if ({o, u, r} !== {2'b00, 32'h40000000} || lat != 5) begin
      errors++; $display("[TB] FAIL midreset_recover got %b%b_%h lat %0d exp 00_40000000 lat 5", o, u, r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic        o, u;
    int          lat;
    start_op(32'h7F7FFFFF, 32'h7F7FFFFF);
    wait_valid(lat);
    finish_op(0, r, o, u);
    checks++;
    if ({o, u, r} !== {2'b10, 32'h7F800000}) begin
      errors++; $display("[TB] FAIL b2b_first got %b%b_%h exp 10_7f800000", o, u, r);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_release got ready=%b valid=%b ovf=%b exp ready=1 valid=0 ovf=0",
               bus.in_ready, bus.out_valid, bus.overflow);
    end
    start_op(32'h00800000, 32'h80C00000);
    wait_valid(lat);
    finish_op(0, r, o, u);
    checks++;
    if ({o, u, r} !== {2'b01, 32'h80000000} || lat != 5) begin
      errors++; $display("[TB] FAIL b2b_second got %b%b_%h lat %0d exp 01_80000000 lat 5", o, u, r, lat);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
